// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the mux4 round-robin arbiter: requester count,
// FSM state encoding and a one-hot helper used for the grant vector.
package mux4_rr_arbiter_pkg;

    localparam int ARB_N_REQ = 4;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_GRANT = 2'd1,
        ARB_ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [ARB_N_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [ARB_N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/arbiter bundle for the mux4 round-robin arbiter.
//
// Handshake: a requester raises req[i] and keeps it high for its whole
// transfer; the transfer owns the mux while gnt[i]=1 (sel_valid=1, sel=i).
// Dropping req[i] ends ownership on the next edge. req must not be dropped
// and re-raised as a way to "keep" a grant: every release costs a gap cycle.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [ARB_N_REQ-1:0] req;
    logic [ARB_N_REQ-1:0] gnt;
    logic [1:0]           sel;
    logic                 sel_valid;
    logic                 busy;
    logic                 timeout;
    arb_state_e           state;      // debug view of the arbiter FSM

    modport master (
        output req,
        input  gnt, sel, sel_valid, busy, timeout, state
    );

    modport slave (
        input  req,
        output gnt, sel, sel_valid, busy, timeout, state
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible requester scanning
// last_ptr+1 .. last_ptr+4 (mod 4). A masked requester is never eligible.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] last_ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [3:0] eligible;
    logic [1:0] cand;

    assign eligible = req & ~mask;

    // Priority scan starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        idx   = last_ptr;
        cand  = last_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + 2'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of mux4: one-hot grant held while the owner
// keeps its request, a one-cycle dead gap between owners, sel driving mux4 s.
// Optional forced release after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    mux4_rr_arbiter_if.slave bus
);

    // The hold counter must be able to reach MAX_HOLD.
    if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("mux4_rr_arbiter: MAX_HOLD does not fit in CNT_W bits");
    end

    arb_state_e           state_q;
    logic [ARB_N_REQ-1:0] gnt_q;
    logic [1:0]           sel_q;
    logic                 sel_valid_q;
    logic                 busy_q;
    logic [1:0]           last_ptr_q;
    logic [ARB_N_REQ-1:0] pick_mask;
    logic                 pick_found;
    logic [1:0]           pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0]     hold_cnt_q;
    logic [ARB_N_REQ-1:0] pen_mask_q;
    logic                 timeout_q;

    assign pick_mask   = pen_mask_q;
    assign bus.timeout = timeout_q;
`else
    assign pick_mask   = '0;
    assign bus.timeout = 1'b0;
`endif

    rr_pick4 u_pick (
        .req      (bus.req),
        .mask     (pick_mask),
        .last_ptr (last_ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Arbiter FSM: arbitrate in IDLE/GAP, hold in GRANT, always pass through GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_ST_IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_ptr_q  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            pen_mask_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q  <= 1'b0;
            pen_mask_q <= pen_mask_q & bus.req;   // penalty lifts once req drops
`endif
            case (state_q)
                ARB_ST_IDLE, ARB_ST_GAP: begin
                    if (pick_found) begin
                        state_q     <= ARB_ST_GRANT;
                        gnt_q       <= onehot4(pick_idx);
                        sel_q       <= pick_idx;
                        sel_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        last_ptr_q  <= pick_idx;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q  <= '0;
`endif
                    end else begin
                        state_q <= ARB_ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ARB_ST_GRANT: begin
                    if (!bus.req[sel_q]) begin
                        state_q     <= ARB_ST_GAP;
                        gnt_q       <= '0;
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt_q == HOLD_LAST) begin
                        state_q            <= ARB_ST_GAP;
                        gnt_q              <= '0;
                        sel_valid_q        <= 1'b0;
                        busy_q             <= 1'b1;
                        timeout_q          <= 1'b1;
                        pen_mask_q[sel_q]  <= 1'b1;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q     <= ARB_ST_IDLE;
                    gnt_q       <= '0;
                    sel_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Honors ARB_TIMEOUT_EN the same way as
// the RTL: the forced-release scenario runs only when the macro is defined.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] own;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic sv, input logic b, input logic to);
        check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        check({tag, ".sel"},       32'(bus.sel),       32'(s));
        check({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(sv));
        check({tag, ".busy"},      32'(bus.busy),      32'(b));
        check({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] r);
        bus.req = r;
    endtask

    // Async reset pulse between edges; leaves time at posedge+1.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        step();
        #1 rst_n = 1'b1;
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_req(4'b0000);
        step();
        step();
        #1 rst_n = 1'b1;

        // Idle with no requests
        for (int c = 0; c < 5; c++) begin
            step();
            check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        check("idle.state", 32'(bus.state), 32'(ARB_ST_IDLE));

        // All four requesting: 0,1,2,3,0 with a gap between owners
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        drive_req(4'b1111);
        for (int n = 0; n < 5; n++) begin
            own = exp_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                step();
                check_out("rr_grant", onehot4(own[1:0]), own[1:0], 1'b1, 1'b1, 1'b0);
            end
            bus.req[own[1:0]] = 1'b0;
            step();
            check_out("rr_gap", 4'b0000, own[1:0], 1'b0, 1'b1, 1'b0);
            check("rr_gap.state", 32'(bus.state), 32'(ARB_ST_GAP));
            if (n == 4) drive_req(4'b0000);
            else        bus.req[own[1:0]] = 1'b1;
        end
        step();
        check_out("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // Lone requester 2, twice
        for (int r = 0; r < 2; r++) begin
            drive_req(4'b0100);
            step();
            check_out("solo_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
            drive_req(4'b0000);
            step();
            check_out("solo_gap", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
            step();
            check_out("solo_idle", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
        end

        // Owner 1 releases as req[3] rises
        drive_req(4'b0010);
        step();
        check_out("hand_g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        check_out("hand_g1b", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        drive_req(4'b1000);
        step();
        check_out("hand_gap", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        check_out("hand_g3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);

        // Non-owner request during a grant is ignored
        drive_req(4'b1001);
        step();
        check_out("ignore_g3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        drive_req(4'b0001);
        step();
        check_out("ignore_gap", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
        step();
        check_out("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        // Previous owner re-requesting in the gap loses to a waiter
        drive_req(4'b0011);
        step();
        check_out("rereq_hold0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        drive_req(4'b0010);
        step();
        check_out("rereq_gap", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        drive_req(4'b0011);
        step();
        check_out("rereq_g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

        // Async reset mid-grant clears outputs with no clock edge
        #1 rst_n = 1'b0;
        #1;
        check_out("arst_now", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        check("arst_now.state", 32'(bus.state), 32'(ARB_ST_IDLE));
        drive_req(4'b0010);
        step();
        check_out("arst_hold", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        check_out("arst_g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

        // Second pulse: last_ptr restarts at 3, so 0 beats 3
        drive_req(4'b1001);
        reset_pulse();
        check_out("arst2_now", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("arst2_g0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        drive_req(4'b0000);
        step();
        step();
        check_out("arst2_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        reset_pulse();
`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD=4 cycles, penalty until req drops
        drive_req(4'b0011);
        for (int c = 0; c < 4; c++) begin
            step();
            check_out("to_g0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        step();
        check_out("to_force0", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            check_out("to_g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
        end
        step();
        check_out("to_force1", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
        step();
        check_out("to_masked", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
        drive_req(4'b0010);
        step();
        check_out("to_still_masked", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
        drive_req(4'b0011);
        step();
        check_out("to_regrant0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
`else
        // Without the timeout a grant lasts as long as the request
        drive_req(4'b0011);
        for (int c = 0; c < 12; c++) begin
            step();
            check_out("long_g0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        drive_req(4'b0010);
        step();
        check_out("long_gap", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        check_out("long_g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
`endif
        drive_req(4'b0000);
        step();
        step();
        check_out("final_idle", 4'b0000, bus.sel, 1'b0, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
